dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a level-based request tuple. Each new
// tuple is serviced once after a fixed LATENCY and acknowledged with data_valid.

module dmem_lane_merge #(
    parameter int VEC_W = 8
) (
    input  logic             en,
    input  logic [VEC_W-1:0] old_lane,
    input  logic [VEC_W-1:0] new_lane,
    output logic [VEC_W-1:0] merged
);
    assign merged = en ? new_lane : old_lane;
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_we,
    input  logic [31:0] mem_data_write,
    output logic [31:0] mem_data_read,
    output logic        mem_data_valid
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int AW        = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic [29:0]                       idx;
        logic [NUM_LANES-1:0]              we;
        logic [NUM_LANES-1:0][VEC_W-1:0]   wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    req_t   pres, tup;
    logic   tv, match, in_range;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic   latch, do_access;
    logic [NUM_LANES-1:0][VEC_W-1:0] rd_word, merged;
    logic   unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[1:0];
    assign pres     = '{idx: mem_addr[31:2], we: mem_we, wdata: mem_data_write};
    assign match    = tv && (pres == tup);
    // Accesses only fire while pres == tup (or on a fresh latch), so the
    // presented tuple is always the one being serviced.
    assign in_range = ({2'b00, pres.idx} < 32'(DEPTH_WORDS));
    assign rd_word  = in_range ? mem[pres.idx[AW-1:0]] : '0;

    genvar i;
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
        dmem_lane_merge #(.VEC_W(VEC_W)) u_merge (
            .en       (pres.we[i]),
            .old_lane (rd_word[i]),
            .new_lane (pres.wdata[i]),
            .merged   (merged[i])
        );
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        do_access = 1'b0;
        if (state == IDLE || !match) begin
            // Fresh tuple (or abort): relatch and restart the count.
            latch = 1'b1;
            if (LATENCY == 1) begin
                state_nxt = DONE;
                cnt_nxt   = '0;
                do_access = 1'b1;
            end else begin
                state_nxt = WAIT;
                cnt_nxt   = 4'(LATENCY - 2);
            end
        end else if (state == WAIT) begin
            if (cnt != '0) begin
                cnt_nxt = cnt - 4'd1;
            end else begin
                state_nxt = DONE;
                do_access = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            tv            <= 1'b0;
            cnt           <= '0;
            mem_data_read <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                tup <= pres;
                tv  <= 1'b1;
            end
            if (do_access)
                mem_data_read <= in_range ? merged : '0;
        end
    end

    // RAM has no reset; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (!reset && do_access && in_range && (pres.we != '0))
            mem[pres.idx[AW-1:0]] <= merged;
    end

    assign mem_data_valid = (state == DONE) && match;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 2/3/4) share one stimulus stream;
// each scenario checks the instance whose latency it targets.

module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_data_write;
    logic [31:0] rd2, rd3, rd4;
    logic        v2, v3, v4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_data_write(mem_data_write), .mem_data_read(rd2), .mem_data_valid(v2));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u3 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_data_write(mem_data_write), .mem_data_read(rd3), .mem_data_valid(v3));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u4 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_data_write(mem_data_write), .mem_data_read(rd4), .mem_data_valid(v4));

    task automatic present(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        mem_addr       = a;
        mem_we         = we;
        mem_data_write = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        present(32'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL reset_v2 got %b want 0", v2); end
        n_cmp++; if (rd2 !== 32'h0) begin n_err++; $display("FAIL reset_rd2 got %h want 0", rd2); end
        n_cmp++; if (v4 !== 1'b0) begin n_err++; $display("FAIL reset_v4 got %b want 0", v4); end
        n_cmp++; if (rd4 !== 32'h0) begin n_err++; $display("FAIL reset_rd4 got %h want 0", rd4); end
        u2.mem[5]  = 32'hDEADBEEF;
        u2.mem[3]  = 32'h11223344;
        u2.mem[0]  = 32'h0BADF00D;
        u3.mem[8]  = 32'h12345678;
        u3.mem[9]  = 32'h99887766;
        u4.mem[7]  = 32'h01020304;
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read_latency();
        present(32'h14, 4'h0, 32'h0);
        @(negedge clk);
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL rd_lat_early got %b want 0", v2); end
        @(negedge clk);
        n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL rd_lat_valid got %b want 1", v2); end
        n_cmp++; if (rd2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_lat_data got %h want deadbeef", rd2); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL rd_lat_hold%0d got %b want 1", k, v2); end
        end
    endtask

    task automatic test_byte_write();
        present(32'h0C, 4'b0101, 32'hAABBCCDD);
        repeat (2) @(negedge clk);
        n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL bw_valid got %b want 1", v2); end
        n_cmp++; if (rd2 !== 32'h11BB33DD) begin n_err++; $display("FAIL bw_merge got %h want 11bb33dd", rd2); end
        n_cmp++; if (u2.mem[3] !== 32'h11BB33DD) begin n_err++; $display("FAIL bw_ram got %h want 11bb33dd", u2.mem[3]); end
        present(32'h0C, 4'h0, 32'h0);
        @(negedge clk);
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL bw_drop got %b want 0", v2); end
        @(negedge clk);
        n_cmp++; if (rd2 !== 32'h11BB33DD || v2 !== 1'b1) begin
            n_err++; $display("FAIL bw_readback got %h/%b want 11bb33dd/1", rd2, v2); end
    endtask

    task automatic test_abort();
        present(32'h20, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        n_cmp++; if (v3 !== 1'b0) begin n_err++; $display("FAIL abort_wr_valid got %b want 0", v3); end
        present(32'h24, 4'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++; if (v3 !== 1'b0) begin n_err++; $display("FAIL abort_early%0d got %b want 0", k, v3); end
        end
        @(negedge clk);
        n_cmp++; if (v3 !== 1'b1) begin n_err++; $display("FAIL abort_rd_valid got %b want 1", v3); end
        n_cmp++; if (rd3 !== 32'h99887766) begin n_err++; $display("FAIL abort_rd_data got %h want 99887766", rd3); end
        n_cmp++; if (u3.mem[8] !== 32'h12345678) begin n_err++; $display("FAIL abort_ram got %h want 12345678", u3.mem[8]); end
    endtask

    task automatic test_hold_no_repeat();
        present(32'h40, 4'hF, 32'h55667788);
        repeat (2) @(negedge clk);
        n_cmp++; if (v2 !== 1'b1 || rd2 !== 32'h55667788) begin
            n_err++; $display("FAIL hold_ack got %h/%b want 55667788/1", rd2, v2); end
        u2.mem[16] = 32'hA5A5A5A5;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL hold_valid%0d got %b want 1", k, v2); end
        end
        n_cmp++; if (u2.mem[16] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL hold_norepeat got %h want a5a5a5a5", u2.mem[16]); end
    endtask

    task automatic test_out_of_range();
        present(32'h1000, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        n_cmp++; if (v2 !== 1'b1 || rd2 !== 32'h0) begin
            n_err++; $display("FAIL oor_read got %h/%b want 0/1", rd2, v2); end
        present(32'h14, 4'h0, 32'h0);
        repeat (2) @(negedge clk);
        n_cmp++; if (rd2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL oor_mid got %h want deadbeef", rd2); end
        present(32'h1000, 4'hF, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        n_cmp++; if (v2 !== 1'b1 || rd2 !== 32'h0) begin
            n_err++; $display("FAIL oor_write got %h/%b want 0/1", rd2, v2); end
        n_cmp++; if (u2.mem[0] !== 32'h0BADF00D) begin n_err++; $display("FAIL oor_ram0 got %h want 0badf00d", u2.mem[0]); end
    endtask

    task automatic test_reset_mid_wait();
        present(32'h1C, 4'hF, 32'hFFFF0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (v4 !== 1'b0 || rd4 !== 32'h0) begin
            n_err++; $display("FAIL rst_wait_out got %h/%b want 0/0", rd4, v4); end
        present(32'h1C, 4'h0, 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (v4 !== 1'b0) begin n_err++; $display("FAIL rst_wait_early got %b want 0", v4); end
        @(negedge clk);
        n_cmp++; if (v4 !== 1'b1 || rd4 !== 32'h01020304) begin
            n_err++; $display("FAIL rst_wait_read got %h/%b want 01020304/1", rd4, v4); end
        n_cmp++; if (u4.mem[7] !== 32'h01020304) begin n_err++; $display("FAIL rst_wait_ram got %h want 01020304", u4.mem[7]); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_byte_write();
        test_abort();
        test_hold_no_repeat();
        test_out_of_range();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
